protected_mem_initiator: RTL and testbench
==========================================

PROTECTED_MEM_INITIATOR -- requirements
Module: protected_mem_initiator

Interface
REQ-001 SHALL have parameter ADDR_W, 32, byte-address width of request and memory address.
REQ-002 SHALL have parameter PRIV_ID, 3'h4, the only usr_id granted data access.
REQ-003 SHALL have parameter IDLE_ID, 3'h0, usr_id driven to memory when no privileged access is in flight.
REQ-004 SHALL have parameter HOLD_CYCLES, 2, cycles usr_id is held before mem_data_out is sampled (min 2).
REQ-005 SHALL have port clk  in  1  clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port req_valid  in  1  host request valid.
REQ-008 SHALL have port req_ready  out  1  initiator accepts a request.
REQ-009 SHALL have port req_addr  in  ADDR_W  request byte address.
REQ-010 SHALL have port req_usr_id  in  3  requester identity.
REQ-011 SHALL have port req_wdata  in  8  data presented to the memory data_in.
REQ-012 SHALL have port rsp_valid  out  1  response valid.
REQ-013 SHALL have port rsp_ready  in  1  host accepts response.
REQ-014 SHALL have port rsp_rdata  out  8  captured memory data_out.
REQ-015 SHALL have port rsp_instr  out  32  captured instruction word.
REQ-016 SHALL have port rsp_err  out  2  status: 00 OK, 01 DENIED, 10 MISALIGNED.
REQ-017 SHALL have ports mem_addr out ADDR_W, mem_usr_id out 3, mem_data_in out 8 (drive memory); mem_data_out in 8, mem_rd_instr in 32 (from memory).

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, DENY, RESP.
REQ-019 SHALL assert req_ready only in IDLE; handshake = req_valid & req_ready.
REQ-020 SHALL on handshake register addr, usr_id, wdata; go ACCESS if usr_id==PRIV_ID and addr[1:0]==0, else DENY.
REQ-021 SHALL check permission before driving mem_usr_id; mem_usr_id = PRIV_ID only in ACCESS, IDLE_ID in every other state.
REQ-022 SHALL hold mem_addr, mem_usr_id, mem_data_in stable for exactly HOLD_CYCLES cycles in ACCESS, counted by a down-counter loaded with HOLD_CYCLES-1.
REQ-023 SHALL in the last ACCESS cycle register mem_data_out into rsp_rdata and mem_rd_instr into rsp_instr, set rsp_err=00, go RESP.
REQ-024 SHALL in DENY (one cycle) set rsp_rdata=0, rsp_instr=0, rsp_err=01 (usr mismatch, priority) or 10 (misaligned only), go RESP; memory never sees the request's usr_id.
REQ-025 SHALL assert rsp_valid only in RESP; rsp_* stable while rsp_valid & !rsp_ready; return to IDLE on rsp_ready.
REQ-026 SHALL give access latency handshake->rsp_valid = HOLD_CYCLES+1 cycles; denied latency = 2 cycles.
REQ-027 SHALL ignore req_* changes outside the handshake cycle; back-to-back requests separated by at least one IDLE cycle.
REQ-028 SHALL drive mem_addr = registered addr in ACCESS, 0 otherwise; mem_data_in = registered wdata in ACCESS, 0 otherwise.

Reset
REQ-029 SHALL on rst_n low immediately force IDLE, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_instr=0, rsp_err=00, mem_usr_id=IDLE_ID, counter=0.
REQ-030 SHALL abort any in-flight access on reset with no response issued.

Structure
REQ-031 SHALL place the FSM state enum, rsp_err code constants and PRIV_ID/IDLE_ID defaults in shared package mem_access_pkg.
REQ-032 SHALL be a single module with no sub-modules.

Verification
REQ-033 SHALL test: usr_id=4, addr=0x8, memory data_out=0xA5 after grant -> rsp_valid 3 cycles after handshake, rsp_rdata=0xA5, rsp_err=00.
REQ-034 SHALL test: usr_id=2, addr=0x8 -> rsp_err=01, rsp_rdata=0, mem_usr_id stays 0 throughout.
REQ-035 SHALL test: usr_id=4, addr=0x6 -> rsp_err=10, no ACCESS cycle.
REQ-036 SHALL test: rsp_ready held low 5 cycles -> rsp_* constant, req_ready=0 until release.
REQ-037 SHALL test: rst_n asserted mid-ACCESS -> rsp_valid=0, mem_usr_id=0 immediately, IDLE after release.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the protected memory initiator: FSM state codes,
// response status codes and the default privileged/idle identities.
package mem_access_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DENY   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef enum logic [1:0] {
    STATE_IDLE   = ST_IDLE,
    STATE_ACCESS = ST_ACCESS,
    STATE_DENY   = ST_DENY,
    STATE_RESP   = ST_RESP
  } state_e;

  localparam logic [1:0] ERR_OK         = 2'b00;
  localparam logic [1:0] ERR_DENIED     = 2'b01;
  localparam logic [1:0] ERR_MISALIGNED = 2'b10;

  localparam logic [2:0] DEF_PRIV_ID = 3'h4;
  localparam logic [2:0] DEF_IDLE_ID = 3'h0;

endpackage

// File: rtl/protected_mem_initiator.sv
// Memory initiator that checks identity and alignment before it ever presents
// the privileged usr_id to memory, then returns one response per request.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both high; valid may not depend on ready, and the response payload is held
// stable while rsp_valid is high and rsp_ready is low.
module protected_mem_initiator
  import mem_access_pkg::*;
#(
  parameter int         ADDR_W      = 32,
  parameter logic [2:0] PRIV_ID     = DEF_PRIV_ID,
  parameter logic [2:0] IDLE_ID     = DEF_IDLE_ID,
  parameter int         HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_usr_id,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_rdata,
  output logic [31:0]       rsp_instr,
  output logic [1:0]        rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_usr_id,
  output logic [7:0]        mem_data_in,
  input  logic [7:0]        mem_data_out,
  input  logic [31:0]       mem_rd_instr,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        usr_q;
  logic [7:0]        wdata_q;
  logic              in_access;

  assign in_access = (state == ST_ACCESS);
  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign dbg_state = state;

  // Memory side is decoded from state only, so reset removes the grant at once.
  assign mem_usr_id  = in_access ? PRIV_ID : IDLE_ID;
  assign mem_addr    = in_access ? addr_q  : '0;
  assign mem_data_in = in_access ? wdata_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      usr_q     <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_instr <= '0;
      rsp_err   <= ERR_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            usr_q   <= req_usr_id;
            wdata_q <= req_wdata;
            if ((req_usr_id == PRIV_ID) && (req_addr[1:0] == 2'b00)) begin
              state <= ST_ACCESS;
              cnt   <= CNT_W'(HOLD_CYCLES - 1);
            end else begin
              state <= ST_DENY;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            rsp_rdata <= mem_data_out;
            rsp_instr <= mem_rd_instr;
            rsp_err   <= ERR_OK;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DENY: begin
          // Identity mismatch takes priority over misalignment.
          rsp_rdata <= '0;
          rsp_instr <= '0;
          rsp_err   <= (usr_q != PRIV_ID) ? ERR_DENIED : ERR_MISALIGNED;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_protected_mem_initiator.sv
// Self-checking bench for protected_mem_initiator: directed scenarios plus
// randomized requests compared against a rule-level reference model.
module tb_protected_mem_initiator;
  import mem_access_pkg::*;

  localparam int         ADDR_W = 32;
  localparam logic [2:0] PRIV   = 3'h4;
  localparam logic [2:0] IDLE   = 3'h0;
  localparam int         HOLD   = 2;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_usr_id;
  logic [7:0]        req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_rdata;
  logic [31:0]       rsp_instr;
  logic [1:0]        rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_usr_id;
  logic [7:0]        mem_data_in;
  logic [7:0]        mem_data_out;
  logic [31:0]       mem_rd_instr;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_arr [0:63];

  protected_mem_initiator #(
    .ADDR_W(ADDR_W), .PRIV_ID(PRIV), .IDLE_ID(IDLE), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_usr_id(req_usr_id), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_instr(rsp_instr), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_usr_id(mem_usr_id), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_rd_instr(mem_rd_instr),
    .dbg_state(dbg_state)
  );

  // Protected memory stub: only answers while the privileged identity is presented.
  assign mem_data_out = (mem_usr_id == PRIV) ? mem_arr[mem_addr[5:0]] : 8'h00;
  assign mem_rd_instr = (mem_usr_id == PRIV) ?
                        {mem_addr[15:0], mem_data_out, ~mem_data_out} : 32'h0;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Driver + scoreboard for one request; expectations come from the access rules.
  task automatic run_txn(input logic [ADDR_W-1:0] a, input logic [2:0] u,
                         input logic [7:0] w, input int stall);
    logic [1:0]  e_err;
    logic [7:0]  e_d;
    logic [31:0] e_i;
    int          e_lat, e_priv;
    int          n, priv_cyc, hold_bad, idle_bad;
    logic [42:0] snap;
    e_err  = (u != PRIV) ? ERR_DENIED : ((a % 4) != 0) ? ERR_MISALIGNED : ERR_OK;
    e_d    = (e_err == ERR_OK) ? mem_arr[a % 64] : 8'h00;
    e_i    = (e_err == ERR_OK) ? {a[15:0], e_d, ~e_d} : 32'h0;
    e_lat  = (e_err == ERR_OK) ? HOLD + 1 : 2;
    e_priv = (e_err == ERR_OK) ? HOLD : 0;

    check("req_ready_before", req_ready, 1'b1);
    req_valid  = 1'b1;
    req_addr   = a;
    req_usr_id = u;
    req_wdata  = w;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_usr_id = PRIV;
    req_wdata  = 8'($urandom);

    n = 0; priv_cyc = 0; hold_bad = 0; idle_bad = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (mem_usr_id === PRIV) begin
        priv_cyc++;
        if (mem_addr !== a || mem_data_in !== w) hold_bad++;
      end else if (mem_usr_id !== IDLE || mem_addr !== '0 || mem_data_in !== 8'h00) begin
        idle_bad++;
      end
      if (rsp_valid === 1'b1 || n > 20) break;
    end
    check("rsp_valid_seen", rsp_valid, 1'b1);
    check("latency", n, e_lat);
    check("priv_cycles", priv_cyc, e_priv);
    check("mem_hold_stable", hold_bad, 0);
    check("mem_idle_values", idle_bad, 0);
    check("rsp_rdata", rsp_rdata, e_d);
    check("rsp_instr", rsp_instr, e_i);
    check("rsp_err", rsp_err, e_err);

    snap = {rsp_valid, rsp_rdata, rsp_instr, rsp_err};
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("rsp_stable", {rsp_valid, rsp_rdata, rsp_instr, rsp_err}, snap);
      check("req_ready_stalled", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_valid_released", rsp_valid, 1'b0);
    check("req_ready_after", req_ready, 1'b1);
  endtask

  initial begin
    req_valid  = 1'b0;
    req_addr   = '0;
    req_usr_id = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b0;
    rst_n      = 1'b1;
    for (int i = 0; i < 64; i++) mem_arr[i] = 8'($urandom);
    mem_arr[8] = 8'hA5;

    #2 rst_n = 1'b0;
    #1;
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_payload", {rsp_rdata, rsp_instr, rsp_err}, 42'h0);
    check("reset_mem_usr_id", mem_usr_id, IDLE);
    do_reset();
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_state", dbg_state, ST_IDLE);

    // privileged aligned read of 0xA5
    run_txn(32'h8, 3'd4, 8'h3C, 0);
    // identity mismatch
    run_txn(32'h8, 3'd2, 8'h11, 0);
    // misaligned privileged request
    run_txn(32'h6, 3'd4, 8'h22, 0);
    // both faults: identity wins
    run_txn(32'h7, 3'd1, 8'h33, 1);
    // long backpressure
    run_txn(32'h10, 3'd4, 8'h44, 5);
    run_txn(32'h9, 3'd3, 8'h55, 5);

    // reset in the middle of an access
    req_valid  = 1'b1;
    req_addr   = 32'h20;
    req_usr_id = PRIV;
    req_wdata  = 8'h66;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("midreset_granted", mem_usr_id, PRIV);
    rst_n = 1'b0;
    #1;
    check("midreset_rsp_valid", rsp_valid, 1'b0);
    check("midreset_mem_usr_id", mem_usr_id, IDLE);
    check("midreset_mem_addr", mem_addr, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_req_ready", req_ready, 1'b1);
    repeat (4) begin
      @(negedge clk);
      check("midreset_no_rsp", {rsp_valid, mem_usr_id}, {1'b0, IDLE});
    end

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      logic [ADDR_W-1:0] a;
      logic [2:0]        u;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      u = ($urandom_range(0, 1) == 1) ? PRIV : 3'($urandom_range(0, 7));
      run_txn(a, u, 8'($urandom), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
